// File: rtl/calc_pkg.sv
// Shared types and constants for the signed keypad calculator controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package calc_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY_A  = 3'd1,
    S_OPERATOR = 3'd2,
    S_ENTRY_B  = 3'd3,
    S_COMPUTE  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [2:0] OP_NEG = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam int RADIX = 10;

  // Keypad codes at or above the radix are not digits.
  function automatic logic is_digit(input logic [3:0] key);
    return key < 4'(RADIX);
  endfunction

  // Only the four defined opcodes count as an operator event.
  function automatic logic is_opcode(input logic [2:0] op);
    return (op == OP_NEG) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/calc_seq_mult.sv
// Signed shift-add multiplier, one multiplier bit per cycle, full 2*DATA_W product.
// Latency: start at edge E, done high during the cycle after edge E+DATA_W-1 (one cycle only).
// Backpressure: none; a new start restarts the unit, nRST low aborts it synchronously.
module calc_seq_mult #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int PW = 2 * DATA_W;
  localparam int CW = $clog2(DATA_W + 1);

  logic [PW-1:0]     acc;
  logic [PW-1:0]     mc_sh;
  logic [DATA_W-1:0] mp;
  logic [CW-1:0]     cnt;
  logic              run;
  logic [PW-1:0]     a_ext;

  assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};

  // The multiplier's top bit carries negative weight, so its partial product is subtracted.
  function automatic logic [PW-1:0] step(input logic [PW-1:0] acc_i,
                                         input logic [PW-1:0] mc_i,
                                         input logic          bit_i,
                                         input logic          last_i);
    if (!bit_i) return acc_i;
    if (last_i) return acc_i - mc_i;
    return acc_i + mc_i;
  endfunction

  // Bit 0 is folded in on the start edge; the remaining DATA_W-1 bits follow one per cycle.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      acc   <= '0;
      mc_sh <= '0;
      mp    <= '0;
      cnt   <= '0;
      run   <= 1'b0;
    end else if (start) begin
      acc   <= step({PW{1'b0}}, a_ext, b[0], 1'b0);
      mc_sh <= a_ext << 1;
      mp    <= b >> 1;
      cnt   <= CW'(1);
      run   <= 1'b1;
    end else if (run) begin
      if (cnt == CW'(DATA_W)) begin
        run <= 1'b0;
      end else begin
        acc   <= step(acc, mc_sh, mp[0], cnt == CW'(DATA_W - 1));
        mc_sh <= mc_sh << 1;
        mp    <= mp >> 1;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  assign done    = run && (cnt == CW'(DATA_W));
  assign product = acc;

endmodule

// File: rtl/calc_ctrl.sv
// Signed decimal calculator controller: keypad entry, negate/add/sub/mul, chaining; CALC_SAT_EN selects saturating results.
// Latency: digit 1 cycle after strobe sample, add/sub result 2 cycles after equal, multiply DATA_W+1 cycles after equal.
// Backpressure: none; events arriving in S_COMPUTE or in states where they have no meaning are dropped.
module calc_ctrl import calc_pkg::*; #(
  parameter int DATA_W     = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [3:0]        keypad_input,
  input  logic              read_input,
  input  logic [2:0]        operator_input,
  input  logic              equal_input,
  output logic              complete,
  output logic              busy,
  output logic              overflow,
  output logic [DATA_W-1:0] display_output,
  output state_t            tb_current_state
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [DATA_W-1:0] HALF    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAXP    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W+3:0] RADIX_W = (DATA_W+4)'(RADIX);
  localparam logic [DATA_W+3:0] HALF_W  = {4'b0000, HALF};

  state_t            state;
  logic              read_s, read_d, eq_s;
  logic [3:0]        key_s;
  logic [2:0]        op_s;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic              sign_a, sign_b;
  logic [CNT_W-1:0]  cnt_a, cnt_b;
  logic [2:0]        opcode;
  logic [DATA_W-1:0] result;
  logic              ovf_r;

  logic              eq_ev, op_ev, dg_ev;
  logic              ent_b, cur_sign, dig_ok;
  logic [DATA_W-1:0] cur_mag, nxt_mag;
  logic [CNT_W-1:0]  cur_cnt;
  logic [DATA_W+3:0] nxt_w;
  logic [DATA_W-1:0] a_val, b_val;
  logic [DATA_W-1:0] sum_v, dif_v, alu_raw, alu_res, neg_res;
  logic              sum_o, dif_o, mul_o, alu_ovf, neg_o;
  logic [DATA_W-1:0] disp;
  logic              mul_start, mul_done;
  logic [2*DATA_W-1:0] mul_p;

  // Signed operand from magnitude and sign; a positive full-scale magnitude clamps to the largest positive value.
  function automatic logic [DATA_W-1:0] to_val(input logic [DATA_W-1:0] m, input logic s);
    if (s) return -m;
    if (m == HALF) return MAXP;
    return m;
  endfunction

  assign a_val = to_val(mag_a, sign_a);
  assign b_val = to_val(mag_b, sign_b);

  // All strobes are registered once, so priority resolves on aligned events: equal, then operator, then digit.
  always_comb begin
    eq_ev = eq_s;
    op_ev = !eq_s && is_opcode(op_s);
    dg_ev = !eq_s && !is_opcode(op_s) && read_s && !read_d && is_digit(key_s);
  end

  // Next magnitude for the operand currently being entered, and whether the digit fits.
  always_comb begin
    ent_b    = (state == S_OPERATOR) || (state == S_ENTRY_B);
    cur_mag  = ent_b ? mag_b  : mag_a;
    cur_sign = ent_b ? sign_b : sign_a;
    cur_cnt  = ent_b ? cnt_b  : cnt_a;
    nxt_w    = {4'b0000, cur_mag} * RADIX_W + {{DATA_W{1'b0}}, key_s};
    nxt_mag  = nxt_w[DATA_W-1:0];
    dig_ok   = (cur_cnt < CNT_W'(MAX_DIGITS)) && (nxt_w <= HALF_W);
  end

  // Raw arithmetic and overflow detection for the latched opcode.
  always_comb begin
    sum_v = a_val + b_val;
    sum_o = (a_val[DATA_W-1] == b_val[DATA_W-1]) && (sum_v[DATA_W-1] != a_val[DATA_W-1]);
    dif_v = a_val - b_val;
    dif_o = (a_val[DATA_W-1] != b_val[DATA_W-1]) && (dif_v[DATA_W-1] != a_val[DATA_W-1]);
    mul_o = !((&mul_p[2*DATA_W-1:DATA_W-1]) || !(|mul_p[2*DATA_W-1:DATA_W-1]));
    neg_o = (result == HALF);
    case (opcode)
      OP_SUB: begin
        alu_raw = dif_v;
        alu_ovf = dif_o;
      end
      OP_MUL: begin
        alu_raw = mul_p[DATA_W-1:0];
        alu_ovf = mul_o;
      end
      default: begin
        alu_raw = sum_v;
        alu_ovf = sum_o;
      end
    endcase
  end

`ifdef CALC_SAT_EN
  logic alu_neg;
  // Sign of the true result picks the saturation rail; add/sub only overflow when it matches A.
  always_comb begin
    alu_neg = (opcode == OP_MUL) ? mul_p[2*DATA_W-1] : a_val[DATA_W-1];
  end
`endif

  // Final result values: saturate on overflow when enabled, otherwise keep the wrapped low bits.
  always_comb begin
    alu_res = alu_raw;
    neg_res = -result;
`ifdef CALC_SAT_EN
    if (alu_ovf) alu_res = alu_neg ? HALF : MAXP;
    if (neg_o) neg_res = MAXP;
`endif
  end

  assign mul_start = eq_ev && (state == S_ENTRY_B) && (opcode == OP_MUL);

  calc_seq_mult #(
    .DATA_W (DATA_W)
  ) u_mult (
    .clk     (clk),
    .nRST    (nRST),
    .start   (mul_start),
    .a       (a_val),
    .b       (b_val),
    .done    (mul_done),
    .product (mul_p)
  );

  // Main FSM: operand entry, operator latch, compute and result/chaining handling.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state  <= S_IDLE;
      read_s <= 1'b0;
      read_d <= 1'b0;
      key_s  <= '0;
      op_s   <= '0;
      eq_s   <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt_a  <= '0;
      cnt_b  <= '0;
      opcode <= '0;
      result <= '0;
      ovf_r  <= 1'b0;
    end else begin
      read_s <= read_input;
      read_d <= read_s;
      key_s  <= keypad_input;
      op_s   <= operator_input;
      eq_s   <= equal_input;
      case (state)
        S_IDLE, S_ENTRY_A: begin
          if (op_ev) begin
            if (op_s == OP_NEG) begin
              sign_a <= ~sign_a;
              if (sign_a && (mag_a == HALF)) ovf_r <= 1'b1;
              state <= S_ENTRY_A;
            end else if (state == S_ENTRY_A) begin
              opcode <= op_s;
              state  <= S_OPERATOR;
            end
          end else if (dg_ev) begin
            state <= S_ENTRY_A;
            if (dig_ok) begin
              mag_a <= nxt_mag;
              cnt_a <= cnt_a + 1'b1;
              if (!cur_sign && (nxt_mag == HALF)) ovf_r <= 1'b1;
            end
          end
        end
        S_OPERATOR, S_ENTRY_B: begin
          if (eq_ev) begin
            if (state == S_ENTRY_B) state <= S_COMPUTE;
          end else if (op_ev) begin
            if (op_s == OP_NEG) begin
              sign_b <= ~sign_b;
              if (sign_b && (mag_b == HALF)) ovf_r <= 1'b1;
              state <= S_ENTRY_B;
            end else if (state == S_OPERATOR) begin
              opcode <= op_s;
            end
          end else if (dg_ev) begin
            state <= S_ENTRY_B;
            if (dig_ok) begin
              mag_b <= nxt_mag;
              cnt_b <= cnt_b + 1'b1;
              if (!cur_sign && (nxt_mag == HALF)) ovf_r <= 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if ((opcode != OP_MUL) || mul_done) begin
            result <= alu_res;
            if (alu_ovf) ovf_r <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (op_ev) begin
            if (op_s == OP_NEG) begin
              result <= neg_res;
              if (neg_o) ovf_r <= 1'b1;
            end else begin
              sign_a <= result[DATA_W-1];
              mag_a  <= result[DATA_W-1] ? -result : result;
              cnt_a  <= '0;
              mag_b  <= '0;
              sign_b <= 1'b0;
              cnt_b  <= '0;
              ovf_r  <= 1'b0;
              opcode <= op_s;
              state  <= S_OPERATOR;
            end
          end else if (dg_ev) begin
            sign_a <= 1'b0;
            mag_b  <= '0;
            sign_b <= 1'b0;
            cnt_b  <= '0;
            opcode <= '0;
            result <= '0;
            ovf_r  <= 1'b0;
            state  <= S_ENTRY_A;
            if ({{DATA_W{1'b0}}, key_s} <= HALF_W) begin
              mag_a <= DATA_W'(key_s);
              cnt_a <= CNT_W'(1);
              if (DATA_W'(key_s) == HALF) ovf_r <= 1'b1;
            end else begin
              mag_a <= '0;
              cnt_a <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Display follows the operand being entered, holds B while computing, then shows the result.
  always_comb begin
    case (state)
      S_OPERATOR, S_ENTRY_B, S_COMPUTE: disp = b_val;
      S_DONE:                           disp = result;
      default:                          disp = a_val;
    endcase
  end

  assign display_output   = disp;
  assign complete         = (state == S_DONE);
  assign busy             = (state == S_COMPUTE);
  assign overflow         = ovf_r;
  assign tb_current_state = state;

endmodule

// File: tb/tb_calc_ctrl.sv
module tb_calc_ctrl;
  import calc_pkg::*;

  logic        clk;
  logic        nRST;
  logic [3:0]  keypad_input;
  logic        read_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        complete;
  logic        busy;
  logic        overflow;
  logic [15:0] display_output;
  state_t      tb_current_state;

  calc_ctrl #(
    .DATA_W     (16),
    .MAX_DIGITS (5)
  ) dut (
    .clk              (clk),
    .nRST             (nRST),
    .keypad_input     (keypad_input),
    .read_input       (read_input),
    .operator_input   (operator_input),
    .equal_input      (equal_input),
    .complete         (complete),
    .busy             (busy),
    .overflow         (overflow),
    .display_output   (display_output),
    .tb_current_state (tb_current_state)
  );

`ifdef CALC_SAT_EN
  localparam int MUL_OVF_EXP = 32'h7FFF;
`else
  localparam int MUL_OVF_EXP = 32'h8000;
`endif

  typedef struct {
    string nm;
    int    disp;
    int    ovf;
    int    lat;
  } res_t;

  typedef struct {
    string nm;
    int    disp;
    int    ovf;
    int    st;
  } snap_t;

  res_t  res_q[$];
  snap_t snap_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    eq_cyc = 0;
  int    snap_req = 0;
  int    snap_done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: results pop on a complete rising edge, snapshots pop when requested.
  task automatic monitor();
    res_t  e;
    snap_t s;
    logic  prev_c = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (complete && !prev_c) begin
        if (res_q.size() == 0) begin
          chk("unexpected_complete", 1, 0);
        end else begin
          e = res_q.pop_front();
          chk({e.nm, "_display"}, int'(display_output), e.disp);
          chk({e.nm, "_overflow"}, int'(overflow), e.ovf);
          chk({e.nm, "_latency"}, cyc - eq_cyc, e.lat);
        end
      end
      prev_c = complete;
      while (snap_done < snap_req) begin
        s = snap_q.pop_front();
        snap_done++;
        chk({s.nm, "_display"}, int'(display_output), s.disp);
        chk({s.nm, "_overflow"}, int'(overflow), s.ovf);
        chk({s.nm, "_state"}, int'(tb_current_state), s.st);
        chk({s.nm, "_complete"}, int'(complete), int'(s.st == int'(S_DONE)));
        chk({s.nm, "_busy"}, int'(busy), int'(s.st == int'(S_COMPUTE)));
      end
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic digit(input logic [3:0] d);
    keypad_input = d;
    read_input   = 1'b1;
    tick();
    read_input   = 1'b0;
    tick(2);
  endtask

  task automatic enter_num(input int v);
    int d[$];
    int x;
    x = v;
    do begin
      d.push_front(x % 10);
      x = x / 10;
    end while (x > 0);
    foreach (d[i]) digit(4'(d[i]));
  endtask

  task automatic oper(input logic [2:0] o);
    operator_input = o;
    tick();
    operator_input = 3'b000;
    tick(2);
  endtask

  task automatic press_equal();
    eq_cyc      = cyc + 1;
    equal_input = 1'b1;
    tick();
    equal_input = 1'b0;
  endtask

  task automatic push_res(input string nm, input int disp, input int ovf, input int lat);
    res_t e;
    e.nm = nm; e.disp = disp; e.ovf = ovf; e.lat = lat;
    res_q.push_back(e);
  endtask

  task automatic snap(input string nm, input int disp, input int ovf, input state_t st);
    snap_t s;
    s.nm = nm; s.disp = disp; s.ovf = ovf; s.st = int'(st);
    snap_q.push_back(s);
    snap_req++;
    tick();
  endtask

  task automatic wait_done(input string nm, input int max);
    int k;
    k = 0;
    while (!complete && k < max) begin
      tick();
      k++;
    end
    if (!complete) chk({nm, "_timeout"}, 0, 1);
    tick();
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick(2);
    nRST = 1'b1;
    tick();
  endtask

  initial begin
    nRST = 1'b0;
    keypad_input = 4'd0;
    read_input = 1'b0;
    operator_input = 3'b000;
    equal_input = 1'b0;
    fork
      monitor();
    join_none
    tick(3);
    snap("reset", 0, 0, S_IDLE);
    nRST = 1'b1;
    tick(2);

    // 2 + 3
    digit(4'd2);
    snap("a_2", 2, 0, S_ENTRY_A);
    oper(OP_ADD);
    snap("op_add", 0, 0, S_OPERATOR);
    digit(4'd3);
    snap("b_3", 3, 0, S_ENTRY_B);
    push_res("add_2_3", 5, 0, 2);
    press_equal();
    wait_done("add_2_3", 40);
    snap("done_5", 5, 0, S_DONE);
    oper(OP_NEG);
    snap("neg_done", 32'hFFFB, 0, S_DONE);

    // -25 + -15
    do_reset();
    snap("reset2", 0, 0, S_IDLE);
    oper(OP_NEG);
    snap("neg_first", 0, 0, S_ENTRY_A);
    enter_num(25);
    snap("a_m25", 32'hFFE7, 0, S_ENTRY_A);
    oper(OP_ADD);
    oper(OP_NEG);
    snap("b_neg0", 0, 0, S_ENTRY_B);
    enter_num(15);
    snap("b_m15", 32'hFFF1, 0, S_ENTRY_B);
    push_res("add_m25_m15", 32'hFFD8, 0, 2);
    press_equal();
    wait_done("add_m25_m15", 40);

    // -32768 + 32767, then a positive 32768 clamps
    do_reset();
    oper(OP_NEG);
    enter_num(32768);
    snap("a_min", 32'h8000, 0, S_ENTRY_A);
    oper(OP_ADD);
    enter_num(32767);
    snap("b_max", 32'h7FFF, 0, S_ENTRY_B);
    push_res("add_min_max", 32'hFFFF, 0, 2);
    press_equal();
    wait_done("add_min_max", 40);
    enter_num(32768);
    snap("clamp_pos", 32'h7FFF, 1, S_ENTRY_A);
    digit(4'd1);
    snap("clamp_sixth", 32'h7FFF, 1, S_ENTRY_A);
    oper(OP_NEG);
    snap("clamp_neg", 32'h8000, 1, S_ENTRY_A);

    // 128 * 256 overflows
    do_reset();
    enter_num(128);
    oper(OP_MUL);
    enter_num(256);
    push_res("mul_ovf", MUL_OVF_EXP, 1, 17);
    press_equal();
    wait_done("mul_ovf", 40);

    // 4 * -3, then chain + 20
    do_reset();
    digit(4'd4);
    oper(OP_MUL);
    oper(OP_NEG);
    digit(4'd3);
    snap("b_m3", 32'hFFFD, 0, S_ENTRY_B);
    push_res("mul_4_m3", 32'hFFF4, 0, 17);
    press_equal();
    wait_done("mul_4_m3", 40);
    oper(OP_ADD);
    snap("chain_op", 0, 0, S_OPERATOR);
    enter_num(20);
    push_res("chain_add", 8, 0, 2);
    press_equal();
    wait_done("chain_add", 40);

    // digit limit, ignored key, operator-over-digit priority, equal with B empty
    do_reset();
    digit(4'd1);
    digit(4'd12);
    enter_num(23456);
    snap("max_digits", 32'h3039, 0, S_ENTRY_A);
    operator_input = OP_ADD;
    keypad_input = 4'd7;
    read_input = 1'b1;
    tick();
    operator_input = 3'b000;
    read_input = 1'b0;
    tick(2);
    snap("op_beats_digit", 0, 0, S_OPERATOR);
    press_equal();
    tick(3);
    snap("equal_b_empty", 0, 0, S_OPERATOR);
    digit(4'd7);
    push_res("add_12345_7", 32'h3040, 0, 2);
    press_equal();
    wait_done("add_12345_7", 40);

    // reset in the middle of a multiply, with equal and a digit strobe on the same edge
    do_reset();
    digit(4'd9);
    oper(OP_MUL);
    digit(4'd9);
    press_equal();
    snap("mul_busy", 9, 0, S_COMPUTE);
    tick(2);
    nRST = 1'b0;
    equal_input = 1'b1;
    read_input = 1'b1;
    keypad_input = 4'd5;
    snap("mid_mul_reset", 0, 0, S_IDLE);
    nRST = 1'b1;
    equal_input = 1'b0;
    read_input = 1'b0;
    tick(25);
    snap("post_reset", 0, 0, S_IDLE);

    tick(3);
    chk("pending_results", res_q.size(), 0);
    chk("pending_snaps", snap_req - snap_done, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Parametrised signed calculator controller, successor to the fixed 16-bit keypad controller. It accumulates two decimal operands from keypad strobes and applies sign toggle, add, subtract or multiply. Multiplication runs on a sequential shift-add unit. The block drives a two's-complement display with an overflow flag, and supports chaining, where the result becomes the next first operand. It sits between the keypad/button debouncers and the display driver.

## Interface
- DATA_W, 16, operand/result width in bits (≥4)
- MAX_DIGITS, 5, maximum decimal digits accepted per operand
- clk  in  1  system clock, all logic on rising edge
- nRST  in  1  reset; synchronous, active-low
- keypad_input  in  4  decimal digit; values 10–15 are ignored
- read_input  in  1  digit strobe; rising-edge detected internally
- operator_input  in  3  001 negate, 010 add, 011 subtract, 100 multiply, others no-op; sampled as a one-cycle level
- equal_input  in  1  evaluate request
- complete  out  1  high while the result is valid (S_DONE)
- busy  out  1  high during S_COMPUTE
- overflow  out  DATA_W? no: 1  sticky for the current calculation; entry clamp or arithmetic overflow
- display_output  out  DATA_W  two's-complement value: operand being entered, or the result
- tb_current_state  out  state_t  current FSM state, for benches

## Operation
- States: S_IDLE=0, S_ENTRY_A=1, S_OPERATOR=2, S_ENTRY_B=3, S_COMPUTE=4, S_DONE=5.
- Digit entry (S_IDLE/S_ENTRY_A → A, S_OPERATOR/S_ENTRY_B → B):
  - The magnitude updates as mag = mag*10 + digit.
  - A digit is rejected if the digit count has reached MAX_DIGITS, or if the new mag would exceed 2^(DATA_W-1).
  - Operand value is −mag if the sign flag is set, else mag.
  - A positive operand with mag = 2^(DATA_W-1) clamps to 2^(DATA_W-1)−1 and sets overflow.
- Negate (001) toggles the sign flag of the operand currently being entered (A in S_IDLE/S_ENTRY_A, B in S_OPERATOR/S_ENTRY_B), then re-evaluates the clamp rule. It is allowed before any digit.
- Transitions:
  - S_IDLE → S_ENTRY_A on a digit or negate.
  - S_ENTRY_A → S_OPERATOR on add, sub or mul; the opcode is latched.
  - S_OPERATOR → S_ENTRY_B on a digit or negate.
  - S_ENTRY_B → S_COMPUTE on equal.
  - S_COMPUTE → S_DONE when the arithmetic finishes.
- Operator press in S_OPERATOR replaces the latched opcode.
- Equal outside S_ENTRY_B is ignored. Equal in S_OPERATOR (B empty) is ignored.
- S_DONE:
  - An add/sub/mul press loads A ← result, clears B and overflow, latches the opcode, and goes to S_OPERATOR (chaining).
  - A digit press clears everything and starts a new A in S_ENTRY_A.
  - Negate in S_DONE negates the displayed result and stays in S_DONE.
- Same-cycle priority: nRST > equal > operator > digit. Lower-priority events in that cycle are dropped.
- Arithmetic:
  - Add and subtract are DATA_W-bit two's complement. Overflow is set when the operand signs make overflow possible and the result sign differs.
  - Multiply forms the full 2·DATA_W product. Overflow is set if the product is not representable in DATA_W bits.
- Display shows the value of the operand being entered; during S_COMPUTE it holds B; in S_DONE it shows the result.

## Timing
- Reset values: all outputs 0; state S_IDLE; operands, sign flags, digit counts, opcode and strobe history cleared.
- Reset is honoured in any state, including mid-multiply. Outputs reach reset values on the edge where nRST is sampled low.
- Digit: read_input rising edge sampled at edge N → display_output updated after edge N+1. Holding read_input high enters exactly one digit.
- Add/sub: equal sampled at edge N → S_COMPUTE for one cycle → complete high after edge N+2.
- Multiply: equal at edge N → busy for DATA_W cycles → complete high after edge N+1+DATA_W.
- complete and the result stay stable until the next accepted event or reset.

## Configuration
- CALC_SAT_EN defined: on any arithmetic overflow the result saturates to 2^(DATA_W-1)−1 (positive true result) or −2^(DATA_W-1) (negative). overflow is still set.
- CALC_SAT_EN undefined: the result is truncated to the low DATA_W bits (wrap), with overflow set.

## Structure
- Package calc_pkg holds:
  - state_t enum, with the encodings above;
  - opcode localparams OP_NEG, OP_ADD, OP_SUB, OP_MUL;
  - the digit radix constant (10).
- Sub-module calc_seq_mult:
  - parameter DATA_W;
  - start/done handshake;
  - signed shift-add multiplier, DATA_W iterations;
  - 2·DATA_W product output;
  - synchronous abort on nRST.

## Test plan
- 2, add, 3, equal → display 5, overflow 0, complete 2 cycles after equal.
- Negate, 25, add, negate, 15, equal → display −40 (0xFFD8 at DATA_W=16).
- Negate, 32768, add, 32767 → −1; then entering a positive 32768 clamps to 32767 with overflow=1.
- 128 mul 256 at DATA_W=16 → overflow=1; display 0x7FFF with CALC_SAT_EN, 0x8000 without. complete exactly 17 cycles after equal.
- 4 mul negate 3 equal → −12; then add, 20, equal → 8 (chaining). Digits beyond MAX_DIGITS and keypad_input 12 are ignored.
- Reset asserted mid-multiply at cycle 5 → state S_IDLE and all outputs 0 after that edge; equal and read_input on the same edge have no effect.
